// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer: one command at a time, drives decoder
// addresses and switch enables, issues inject/tunnel pulses and runs a measure loop.
module fg_prog_sequencer #(
  parameter int ISL_W         = 1,
  parameter int ROW_W         = 2,
  parameter int COL_W         = 3,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ISL_W-1:0] cmd_island,
  input  logic [ROW_W-1:0] cmd_row,
  input  logic [COL_W-1:0] cmd_col,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_pulse_width,
  input  logic [7:0]       cmd_max_pulses,
  input  logic             abort,
  output logic             meas_start,
  input  logic             meas_done,
  input  logic             meas_above,
  output logic [ISL_W-1:0] island_sel,
  output logic [ROW_W-1:0] row_addr,
  output logic [COL_W-1:0] col_addr,
  output logic             decode_en,
  output logic             drain_sel_en,
  output logic             prog_sw_en,
  output logic             inj_pulse,
  output logic             tunnel_en,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [7:0]       rsp_count
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, MEASURE, RESP} state_t;

  localparam logic [1:0] M_INJ = 2'b00, M_TUN = 2'b01, M_READ = 2'b10, M_ILL = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_BELOW = 2'b01, ST_ILL = 2'b10, ST_ABORT = 2'b11;
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] pw_q;
  logic [7:0]       max_q;
  logic [CNT_W-1:0] tmr;

  logic active, bad_cmd;
  assign active  = (state == SETUP) || (state == PULSE) || (state == GAP) || (state == MEASURE);
  assign bad_cmd = (cmd_mode == M_ILL) ||
                   ((cmd_mode != M_READ) && ((cmd_max_pulses == 8'd0) || (cmd_pulse_width == '0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      mode_q       <= M_INJ;
      pw_q         <= '0;
      max_q        <= '0;
      tmr          <= '0;
      meas_start   <= 1'b0;
      island_sel   <= '0;
      row_addr     <= '0;
      col_addr     <= '0;
      decode_en    <= 1'b0;
      drain_sel_en <= 1'b0;
      prog_sw_en   <= 1'b0;
      inj_pulse    <= 1'b0;
      tunnel_en    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_status   <= '0;
      rsp_count    <= '0;
    end else begin
      meas_start <= 1'b0;
      // Abort beats everything else, including a coincident meas_done.
      if (abort && active) begin
        state        <= RESP;
        decode_en    <= 1'b0;
        drain_sel_en <= 1'b0;
        prog_sw_en   <= 1'b0;
        inj_pulse    <= 1'b0;
        tunnel_en    <= 1'b0;
        rsp_valid    <= 1'b1;
        rsp_status   <= ST_ABORT;
      end else begin
        case (state)
          IDLE: if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            island_sel <= cmd_island;
            row_addr   <= cmd_row;
            col_addr   <= cmd_col;
            mode_q     <= cmd_mode;
            pw_q       <= cmd_pulse_width;
            max_q      <= cmd_max_pulses;
            rsp_count  <= '0;
            if (bad_cmd) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_ILL;
            end else begin
              state        <= SETUP;
              tmr          <= SETTLE_M1;
              decode_en    <= 1'b1;
              drain_sel_en <= 1'b1;
              prog_sw_en   <= (cmd_mode == M_INJ);
            end
          end
          SETUP, GAP: begin
            if (tmr != '0) tmr <= tmr - 1'b1;
            else if (state == SETUP && mode_q == M_READ) begin
              state      <= MEASURE;
              meas_start <= 1'b1;
            end else begin
              state     <= PULSE;
              tmr       <= pw_q - 1'b1;
              inj_pulse <= (mode_q == M_INJ);
              tunnel_en <= (mode_q == M_TUN);
            end
          end
          PULSE: begin
            if (tmr != '0) tmr <= tmr - 1'b1;
            else begin
              state      <= MEASURE;
              meas_start <= 1'b1;
              inj_pulse  <= 1'b0;
              tunnel_en  <= 1'b0;
              if (rsp_count != 8'hFF) rsp_count <= rsp_count + 8'd1;
            end
          end
          MEASURE: begin
            // meas_done is ignored during the request cycle itself.
            if (meas_done && !meas_start) begin
              if (meas_above || mode_q == M_READ || rsp_count == max_q) begin
                state        <= RESP;
                decode_en    <= 1'b0;
                drain_sel_en <= 1'b0;
                prog_sw_en   <= 1'b0;
                rsp_valid    <= 1'b1;
                rsp_status   <= meas_above ? ST_OK : ST_BELOW;
              end else begin
                state <= GAP;
                tmr   <= SETTLE_M1;
              end
            end
          end
          RESP: if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed bench for fg_prog_sequencer: one task per scenario, inline checks.
module tb_fg_prog_sequencer;
  logic       clk = 1'b0, rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [0:0] cmd_island = '0;
  logic [1:0] cmd_row = '0;
  logic [2:0] cmd_col = '0;
  logic [1:0] cmd_mode = '0;
  logic [15:0] cmd_pulse_width = '0;
  logic [7:0] cmd_max_pulses = '0;
  logic       abort = 1'b0, meas_start, meas_done = 1'b0, meas_above = 1'b0;
  logic [0:0] island_sel;
  logic [1:0] row_addr;
  logic [2:0] col_addr;
  logic       decode_en, drain_sel_en, prog_sw_en, inj_pulse, tunnel_en;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [1:0] rsp_status;
  logic [7:0] rsp_count;

  int vec = 0, errs = 0;

  fg_prog_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_island(cmd_island), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_mode(cmd_mode),
    .cmd_pulse_width(cmd_pulse_width), .cmd_max_pulses(cmd_max_pulses), .abort(abort),
    .meas_start(meas_start), .meas_done(meas_done), .meas_above(meas_above),
    .island_sel(island_sel), .row_addr(row_addr), .col_addr(col_addr), .decode_en(decode_en),
    .drain_sel_en(drain_sel_en), .prog_sw_en(prog_sw_en), .inj_pulse(inj_pulse),
    .tunnel_en(tunnel_en), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  // Pulses must be exclusive and only with decoders enabled.
  always @(negedge clk) if (!rst) begin
    vec++;
    if ((inj_pulse && tunnel_en) || ((inj_pulse || tunnel_en) && !decode_en)) begin
      errs++; $display("FAIL pulse_guard inj=%0b tun=%0b dec=%0b", inj_pulse, tunnel_en, decode_en);
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic send(input logic [0:0] isl, input logic [1:0] row, input logic [2:0] col,
                      input logic [1:0] mode, input logic [15:0] w, input logic [7:0] mx);
    cmd_island = isl; cmd_row = row; cmd_col = col; cmd_mode = mode;
    cmd_pulse_width = w; cmd_max_pulses = mx; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_meas(output int n, output int p_inj, output int p_tun, output int sw);
    n = 0; p_inj = 0; p_tun = 0; sw = 0;
    while (!meas_start && n < 200) begin
      p_inj += int'(inj_pulse); p_tun += int'(tunnel_en); sw |= int'(prog_sw_en);
      tick(); n++;
    end
  endtask

  task automatic run_meas(input int d, input logic above);
    repeat (d) tick();
    meas_done = 1'b1; meas_above = above;
    tick();
    meas_done = 1'b0; meas_above = 1'b0;
  endtask

  task automatic release_rsp(); rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    vec++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %0b exp 1", cmd_ready); end
    vec++; if ({rsp_valid, decode_en, drain_sel_en, prog_sw_en, inj_pulse, tunnel_en, meas_start} !== 7'b0) begin
      errs++; $display("FAIL rst_flags got %b exp 0", {rsp_valid, decode_en, drain_sel_en, prog_sw_en, inj_pulse, tunnel_en, meas_start}); end
    vec++; if ({island_sel, row_addr, col_addr, rsp_status, rsp_count} !== 16'h0) begin
      errs++; $display("FAIL rst_vals got %h exp 0", {island_sel, row_addr, col_addr, rsp_status, rsp_count}); end
  endtask

  task automatic test_inject();
    int n, pi, pt, sw;
    send(1'b0, 2'd1, 3'd2, 2'b00, 16'd4, 8'd3);
    vec++; if ({cmd_ready, decode_en, drain_sel_en, prog_sw_en, inj_pulse} !== 5'b01110) begin
      errs++; $display("FAIL inj_setup got %b exp 01110", {cmd_ready, decode_en, drain_sel_en, prog_sw_en, inj_pulse}); end
    wait_meas(n, pi, pt, sw);
    vec++; if (n !== 12) begin errs++; $display("FAIL inj_lat1 got %0d exp 12", n); end
    vec++; if (pi !== 4 || pt !== 0) begin errs++; $display("FAIL inj_pw1 got %0d/%0d exp 4/0", pi, pt); end
    run_meas(2, 1'b0);
    vec++; if ({rsp_valid, inj_pulse, decode_en, prog_sw_en} !== 4'b0011) begin
      errs++; $display("FAIL inj_gap got %b exp 0011", {rsp_valid, inj_pulse, decode_en, prog_sw_en}); end
    wait_meas(n, pi, pt, sw);
    vec++; if (n !== 12 || pi !== 4) begin errs++; $display("FAIL inj_lat2 got %0d/%0d exp 12/4", n, pi); end
    run_meas(1, 1'b1);
    vec++; if ({rsp_valid, decode_en, drain_sel_en, prog_sw_en} !== 4'b1000) begin
      errs++; $display("FAIL inj_rsp got %b exp 1000", {rsp_valid, decode_en, drain_sel_en, prog_sw_en}); end
    for (int i = 0; i < 5; i++) begin
      vec++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd0 || rsp_count !== 8'd2 || cmd_ready !== 1'b0) begin
        errs++; $display("FAIL inj_hold%0d got v%0b s%0d c%0d exp v1 s0 c2", i, rsp_valid, rsp_status, rsp_count); end
      tick();
    end
    release_rsp();
    vec++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errs++; $display("FAIL inj_done got r%0b v%0b exp r1 v0", cmd_ready, rsp_valid); end
  endtask

  task automatic test_tunnel();
    int n, pi, pt, sw, tot_t = 0, any_sw = 0;
    send(1'b1, 2'd0, 3'd4, 2'b01, 16'd2, 8'd3);
    for (int k = 0; k < 3; k++) begin
      wait_meas(n, pi, pt, sw);
      tot_t += pt; any_sw |= sw;
      vec++; if (n !== 10 || pi !== 0) begin errs++; $display("FAIL tun_lat%0d got %0d/%0d exp 10/0", k, n, pi); end
      run_meas(1, 1'b0);
    end
    vec++; if (tot_t !== 6 || any_sw !== 0) begin errs++; $display("FAIL tun_pulses got %0d sw%0d exp 6 sw0", tot_t, any_sw); end
    vec++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd1 || rsp_count !== 8'd3) begin
      errs++; $display("FAIL tun_rsp got v%0b s%0d c%0d exp v1 s1 c3", rsp_valid, rsp_status, rsp_count); end
    release_rsp();
  endtask

  task automatic test_illegal();
    logic [1:0]  modes [3] = '{2'b11, 2'b00, 2'b01};
    logic [15:0] ws    [3] = '{16'd4, 16'd4, 16'd0};
    logic [7:0]  mxs   [3] = '{8'd3, 8'd0, 8'd3};
    for (int k = 0; k < 3; k++) begin
      send(1'b0, 2'd2, 3'd1, modes[k], ws[k], mxs[k]);
      vec++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd2 || rsp_count !== 8'd0 || decode_en !== 1'b0) begin
        errs++; $display("FAIL ill%0d got v%0b s%0d c%0d d%0b exp v1 s2 c0 d0", k, rsp_valid, rsp_status, rsp_count, decode_en); end
      tick();
      vec++; if (decode_en !== 1'b0 || rsp_valid !== 1'b1) begin errs++; $display("FAIL ill%0d_hold got d%0b v%0b exp d0 v1", k, decode_en, rsp_valid); end
      release_rsp();
    end
  endtask

  task automatic test_read();
    int n, pi, pt, sw;
    send(1'b1, 2'd3, 3'd7, 2'b10, 16'd5, 8'd0);
    vec++; if ({island_sel, row_addr, col_addr} !== 6'b1_11_111 || prog_sw_en !== 1'b0 || decode_en !== 1'b1) begin
      errs++; $display("FAIL rd_addr got %b sw%0b exp 111111 sw0", {island_sel, row_addr, col_addr}, prog_sw_en); end
    wait_meas(n, pi, pt, sw);
    vec++; if (n !== 8 || pi + pt !== 0) begin errs++; $display("FAIL rd_lat got %0d p%0d exp 8 p0", n, pi + pt); end
    tick();
    vec++; if (meas_start !== 1'b0) begin errs++; $display("FAIL rd_mstart got %0b exp 0", meas_start); end
    run_meas(2, 1'b1);
    vec++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd0 || {island_sel, row_addr, col_addr} !== 6'b1_11_111) begin
      errs++; $display("FAIL rd_rsp got v%0b s%0d a%b exp v1 s0 a111111", rsp_valid, rsp_status, {island_sel, row_addr, col_addr}); end
    release_rsp();
    vec++; if ({island_sel, row_addr, col_addr} !== 6'b1_11_111) begin
      errs++; $display("FAIL rd_idle_addr got %b exp 111111", {island_sel, row_addr, col_addr}); end
    send(1'b0, 2'd2, 3'd5, 2'b10, 16'd1, 8'd1);
    wait_meas(n, pi, pt, sw);
    run_meas(1, 1'b0);
    vec++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd1 || {island_sel, row_addr, col_addr} !== 6'b0_10_101) begin
      errs++; $display("FAIL rd2_rsp got v%0b s%0d a%b exp v1 s1 a010101", rsp_valid, rsp_status, {island_sel, row_addr, col_addr}); end
    release_rsp();
  endtask

  task automatic test_abort();
    int n, pi, pt, sw;
    send(1'b0, 2'd1, 3'd1, 2'b00, 16'd10, 8'd3);
    repeat (8) tick();
    vec++; if (inj_pulse !== 1'b1) begin errs++; $display("FAIL ab_pulse_on got %0b exp 1", inj_pulse); end
    tick(); abort = 1'b1; tick(); abort = 1'b0;
    vec++; if ({inj_pulse, decode_en, rsp_valid} !== 3'b001 || rsp_status !== 2'd3 || rsp_count !== 8'd0) begin
      errs++; $display("FAIL ab_pulse got %b s%0d c%0d exp 001 s3 c0", {inj_pulse, decode_en, rsp_valid}, rsp_status, rsp_count); end
    release_rsp();
    send(1'b0, 2'd1, 3'd1, 2'b00, 16'd3, 8'd3);
    wait_meas(n, pi, pt, sw);
    vec++; if (n !== 11 || pi !== 3) begin errs++; $display("FAIL ab_lat got %0d/%0d exp 11/3", n, pi); end
    run_meas(1, 1'b0);
    tick(); tick(); abort = 1'b1; tick(); abort = 1'b0;
    vec++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd3 || rsp_count !== 8'd1 || decode_en !== 1'b0) begin
      errs++; $display("FAIL ab_gap got v%0b s%0d c%0d exp v1 s3 c1", rsp_valid, rsp_status, rsp_count); end
    release_rsp();
    send(1'b0, 2'd0, 3'd0, 2'b10, 16'd1, 8'd1);
    wait_meas(n, pi, pt, sw);
    tick(); meas_done = 1'b1; meas_above = 1'b1; abort = 1'b1;
    tick(); meas_done = 1'b0; meas_above = 1'b0; abort = 1'b0;
    vec++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd3) begin
      errs++; $display("FAIL ab_vs_done got v%0b s%0d exp v1 s3", rsp_valid, rsp_status); end
    release_rsp();
  endtask

  task automatic test_rst_mid();
    send(1'b1, 2'd2, 3'd3, 2'b00, 16'd10, 8'd3);
    repeat (9) tick();
    rst = 1'b1; tick();
    vec++; if ({inj_pulse, decode_en, drain_sel_en, prog_sw_en, rsp_valid, cmd_ready} !== 6'b000001) begin
      errs++; $display("FAIL rstmid got %b exp 000001", {inj_pulse, decode_en, drain_sel_en, prog_sw_en, rsp_valid, cmd_ready}); end
    vec++; if ({island_sel, row_addr, col_addr, rsp_count} !== 14'h0) begin
      errs++; $display("FAIL rstmid_vals got %h exp 0", {island_sel, row_addr, col_addr, rsp_count}); end
    rst = 1'b0; repeat (3) tick();
    vec++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errs++; $display("FAIL rstmid_norsp got v%0b r%0b exp v0 r1", rsp_valid, cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_inject();
    test_tunnel();
    test_illegal();
    test_read();
    test_abort();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
